// File: rtl/mem_arbiter.sv
// Shares one single-port block RAM between instruction fetch and load/store.
// Fixed three-cycle transactions. Data wins ties, but fetch is guaranteed a turn after MAX_WAIT losses.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    output logic                    i_ack,
    input  logic                    d_req,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH/8-1:0] d_wmask,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_ack,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    output logic                    mem_rstrb,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    busy
);

    localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH  = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state, state_d;
    logic                   grant_data, grant_data_d;
    logic                   pick_data;
    logic [CNT_WIDTH-1:0]   wait_cnt, wait_cnt_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_d;
    logic [DATA_WIDTH-1:0]  mem_wdata_d;
    logic [MASK_WIDTH-1:0]  mem_wmask_d;
    logic                   mem_rstrb_d;
    logic                   i_ack_d, d_ack_d;
    logic                   busy_d;

    // Read data is shared; only the ack tells a port it is meant for it.
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    // Next state, arbitration and next values of every registered output.
    always_comb begin
        state_d      = state;
        grant_data_d = grant_data;
        pick_data    = 1'b0;
        wait_cnt_d   = wait_cnt;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        mem_wmask_d  = '0;
        mem_rstrb_d  = 1'b0;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;

        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    pick_data    = d_req && !(i_req && (wait_cnt == CNT_MAX));
                    grant_data_d = pick_data;
                    state_d      = ISSUE;
                    if (pick_data) begin
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_wmask_d = d_wmask;
                        mem_rstrb_d = (d_wmask == '0);
                        // Fetch lost a contested round: count toward its guaranteed turn.
                        if (i_req && (wait_cnt != CNT_MAX)) begin
                            wait_cnt_d = wait_cnt + CNT_WIDTH'(1);
                        end
                    end else begin
                        mem_addr_d  = i_addr;
                        mem_rstrb_d = 1'b1;
                        wait_cnt_d  = '0;
                    end
                end
            end
            ISSUE: begin
                state_d = DONE;
                i_ack_d = !grant_data;
                d_ack_d = grant_data;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset drops any in-flight strobe or ack.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            grant_data <= 1'b0;
            wait_cnt   <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            mem_rstrb  <= 1'b0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            grant_data <= grant_data_d;
            wait_cnt   <= wait_cnt_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            mem_wmask  <= mem_wmask_d;
            mem_rstrb  <= mem_rstrb_d;
            i_ack      <= i_ack_d;
            d_ack      <= d_ack_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized-protocol bench for mem_arbiter with a byte-writable RAM model.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = DW / 8;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ack;
    logic          d_req;
    logic [AW-1:0] d_addr;
    logic [MW-1:0] d_wmask;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [MW-1:0] mem_wmask;
    logic          mem_rstrb;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ram [64];

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_addr(d_addr), .d_wmask(d_wmask), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // RAM model: registered read, byte-masked write, preloaded during reset.
    always @(posedge CLK) begin
        if (RESET) begin
            for (int k = 0; k < 64; k++) ram[k] <= 32'h0100_0000 + 32'(k);
            ram[4] <= 32'hDEAD_BEEF;
            ram[8] <= 32'hAABB_CCDD;
        end else begin
            if (mem_rstrb) mem_rdata <= ram[mem_addr[7:2]];
            for (int b = 0; b < 4; b++) begin
                if (mem_wmask[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic exp_i;
    logic p1, p2, smp;

    initial begin
        RESET = 1'b1; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_addr = '0; d_wmask = '0; d_wdata = '0;
        tick(); tick();
        check("rst_i_ack", 64'(i_ack), 64'd0);
        check("rst_d_ack", 64'(d_ack), 64'd0);
        check("rst_rstrb", 64'(mem_rstrb), 64'd0);
        check("rst_wmask", 64'(mem_wmask), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_wait", 64'(dut.wait_cnt), 64'd0);
        RESET = 1'b0;

        // Single fetch
        i_req = 1'b1; i_addr = 32'h10;
        tick();
        check("f_rstrb", 64'(mem_rstrb), 64'd1);
        check("f_addr", 64'(mem_addr), 64'h10);
        check("f_wmask", 64'(mem_wmask), 64'd0);
        check("f_busy", 64'(busy), 64'd1);
        check("f_early_ack", 64'(i_ack), 64'd0);
        tick();
        check("f_ack", 64'(i_ack), 64'd1);
        check("f_rdata", 64'(i_rdata), 64'hDEAD_BEEF);
        check("f_d_ack", 64'(d_ack), 64'd0);
        check("f_rstrb_off", 64'(mem_rstrb), 64'd0);
        i_req = 1'b0;
        tick();
        check("f_ack_off", 64'(i_ack), 64'd0);
        check("f_idle", 64'(busy), 64'd0);

        // Partial data write then read-back
        d_req = 1'b1; d_addr = 32'h20; d_wmask = 4'b0011; d_wdata = 32'h1234_5678;
        tick();
        check("w_wmask", 64'(mem_wmask), 64'h3);
        check("w_rstrb", 64'(mem_rstrb), 64'd0);
        check("w_addr", 64'(mem_addr), 64'h20);
        check("w_wdata", 64'(mem_wdata), 64'h1234_5678);
        tick();
        check("w_wmask_once", 64'(mem_wmask), 64'd0);
        check("w_ack", 64'(d_ack), 64'd1);
        check("w_i_ack", 64'(i_ack), 64'd0);
        d_req = 1'b0;
        tick();
        d_req = 1'b1; d_wmask = 4'b0000;
        tick();
        check("r_rstrb", 64'(mem_rstrb), 64'd1);
        tick();
        check("r_ack", 64'(d_ack), 64'd1);
        check("r_merge", 64'(d_rdata), 64'hAABB_5678);
        d_req = 1'b0;
        tick();

        // Contested arbitration: both held, expect D,D,D,D,I repeating
        i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1;
        for (int t = 0; t < 10; t++) begin
            exp_i = ((t % 5) == 4);
            tick(); tick();
            check($sformatf("arb%0d_i_ack", t), 64'(i_ack), 64'(exp_i));
            check($sformatf("arb%0d_d_ack", t), 64'(d_ack), 64'(!exp_i));
            if (exp_i) begin
                check($sformatf("arb%0d_wait", t), 64'(dut.wait_cnt), 64'd0);
                check($sformatf("arb%0d_idata", t), 64'(i_rdata), 64'hDEAD_BEEF);
            end else begin
                check($sformatf("arb%0d_ddata", t), 64'(d_rdata), 64'hAABB_5678);
            end
            tick();
        end

        // Two D wins, then lone fetch wins immediately and clears the counter
        repeat (6) tick();
        check("lone_wait2", 64'(dut.wait_cnt), 64'd2);
        d_req = 1'b0;
        tick();
        check("lone_rstrb", 64'(mem_rstrb), 64'd1);
        check("lone_addr", 64'(mem_addr), 64'h10);
        tick();
        check("lone_ack", 64'(i_ack), 64'd1);
        check("lone_wait0", 64'(dut.wait_cnt), 64'd0);
        i_req = 1'b0;
        tick();

        // Reset during ISSUE suppresses the ack
        i_req = 1'b1;
        tick();
        check("mr_issue", 64'(busy), 64'd1);
        RESET = 1'b1;
        tick();
        check("mr_busy", 64'(busy), 64'd0);
        check("mr_ack", 64'(i_ack), 64'd0);
        check("mr_rstrb", 64'(mem_rstrb), 64'd0);
        RESET = 1'b0;
        tick();
        check("mr_no_late_ack", 64'(i_ack), 64'd0);
        check("mr_rstrb2", 64'(mem_rstrb), 64'd1);
        tick();
        check("mr_ack2", 64'(i_ack), 64'd1);
        check("mr_rdata2", 64'(i_rdata), 64'hDEAD_BEEF);
        i_req = 1'b0;
        tick();

        // Random protocol mix
        p1 = 1'b0; p2 = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            check("rnd_two_acks", 64'(i_ack & d_ack), 64'd0);
            check("rnd_overlap", 64'(mem_rstrb && (mem_wmask != '0)), 64'd0);
            check("rnd_ack_timing", 64'(i_ack | d_ack), 64'(p2));
            if (i_ack) i_req = 1'b0;
            else if (!i_req && ($urandom_range(0, 2) == 0)) begin
                i_req  = 1'b1;
                i_addr = 32'($urandom_range(0, 63)) << 2;
            end
            if (d_ack) d_req = 1'b0;
            else if (!d_req && ($urandom_range(0, 1) == 0)) begin
                d_req   = 1'b1;
                d_addr  = 32'($urandom_range(0, 63)) << 2;
                d_wmask = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
                d_wdata = $urandom;
            end
            smp = !busy && (i_req || d_req);
            p2 = p1;
            p1 = smp;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
